// File: rtl/aurora_link_ctrl.sv
// rtl/aurora_link_ctrl.sv - Aurora link bring-up sequencer with timeout/retry and link statistics.
// Drives pma_init/reset_pb through the reset ladder, qualifies link stability and counts drops/soft errors.
module aurora_link_ctrl #(
  parameter int NUM_LANES       = 2,
  parameter int PMA_INIT_CYCLES = 128,
  parameter int RESET_PB_CYCLES = 64,
  parameter int UP_TIMEOUT      = 1000000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 8,
  parameter int CNT_W           = 16
) (
  input  logic                 sysclk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [NUM_LANES-1:0] lane_up_i,
  input  logic                 channel_up_i,
  input  logic                 hard_err_i,
  input  logic                 soft_err_i,
  input  logic                 clear_counters_i,
  output logic                 pma_init_o,
  output logic                 reset_pb_o,
  output logic                 link_ok_o,
  output logic                 fail_o,
  output logic [2:0]           state_o,
  output logic [7:0]           retry_count_o,
  output logic [CNT_W-1:0]     drop_count_o,
  output logic [CNT_W-1:0]     soft_err_count_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PMA_RST = 3'd1,
    S_PB_RST  = 3'd2,
    S_WAIT_UP = 3'd3,
    S_STABLE  = 3'd4,
    S_UP      = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  localparam int PH_MAX0 = (PMA_INIT_CYCLES > RESET_PB_CYCLES) ? PMA_INIT_CYCLES : RESET_PB_CYCLES;
  localparam int PH_MAX  = (PH_MAX0 > STABLE_CYCLES) ? PH_MAX0 : STABLE_CYCLES;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int TMO_W   = $clog2(UP_TIMEOUT + 1);

  localparam logic [PH_W-1:0]  PMA_LAST    = PH_W'(PMA_INIT_CYCLES - 1);
  localparam logic [PH_W-1:0]  PB_LAST     = PH_W'(RESET_PB_CYCLES - 1);
  localparam logic [PH_W-1:0]  STABLE_LAST = PH_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(UP_TIMEOUT - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  // Two-flop synchronisers; serr_s3_q is the delayed copy for edge detection.
  logic [NUM_LANES-1:0] lane_s1_q, lane_s2_q;
  logic chan_s1_q, chan_s2_q;
  logic herr_s1_q, herr_s2_q;
  logic serr_s1_q, serr_s2_q, serr_s3_q;

  always_ff @(posedge sysclk_i or posedge reset_i) begin
    if (reset_i) begin
      lane_s1_q <= '0;
      lane_s2_q <= '0;
      chan_s1_q <= 1'b0;
      chan_s2_q <= 1'b0;
      herr_s1_q <= 1'b0;
      herr_s2_q <= 1'b0;
      serr_s1_q <= 1'b0;
      serr_s2_q <= 1'b0;
      serr_s3_q <= 1'b0;
    end else begin
      lane_s1_q <= lane_up_i;
      lane_s2_q <= lane_s1_q;
      chan_s1_q <= channel_up_i;
      chan_s2_q <= chan_s1_q;
      herr_s1_q <= hard_err_i;
      herr_s2_q <= herr_s1_q;
      serr_s1_q <= soft_err_i;
      serr_s2_q <= serr_s1_q;
      serr_s3_q <= serr_s2_q;
    end
  end

  logic all_up, link_good, serr_rise;
  assign all_up    = (&lane_s2_q) & chan_s2_q;
  assign link_good = all_up & ~herr_s2_q;
  assign serr_rise = serr_s2_q & ~serr_s3_q;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        retry_q, retry_d;
  logic              drop_inc;
  logic              pma_init_q, reset_pb_q, link_ok_q, fail_q;
  logic [CNT_W-1:0]  drop_q, serr_cnt_q;

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    drop_inc = 1'b0;
    if (!enable_i) begin
      state_d  = S_IDLE;
      retry_d  = '0;
      ph_cnt_d = '0;
      tmo_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_PMA_RST;
          ph_cnt_d = '0;
        end
        S_PMA_RST: begin
          if (ph_cnt_q == PMA_LAST) begin
            state_d  = S_PB_RST;
            ph_cnt_d = '0;
          end else begin
            ph_cnt_d = ph_cnt_q + PH_W'(1);
          end
        end
        S_PB_RST: begin
          if (ph_cnt_q == PB_LAST) begin
            state_d = S_WAIT_UP;
            tmo_d   = '0;
          end else begin
            ph_cnt_d = ph_cnt_q + PH_W'(1);
          end
        end
        S_WAIT_UP, S_STABLE: begin
          // One timer spans WAIT_UP and STABLE so flapping cannot postpone the timeout.
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) begin
            retry_d  = retry_q + 8'd1;
            state_d  = (retry_q + 8'd1 == RETRY_MAX) ? S_FAIL : S_PMA_RST;
            ph_cnt_d = '0;
          end else if (state_q == S_WAIT_UP) begin
            if (link_good) begin
              state_d  = S_STABLE;
              ph_cnt_d = '0;
            end
          end else if (!link_good) begin
            state_d = S_WAIT_UP;
          end else if (ph_cnt_q == STABLE_LAST) begin
            state_d = S_UP;
            retry_d = '0;
          end else begin
            ph_cnt_d = ph_cnt_q + PH_W'(1);
          end
        end
        S_UP: begin
          if (!link_good) begin
            drop_inc = 1'b1;
            state_d  = S_PMA_RST;
            ph_cnt_d = '0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      ph_cnt_q   <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      pma_init_q <= 1'b1;
      reset_pb_q <= 1'b1;
      link_ok_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      pma_init_q <= state_d inside {S_IDLE, S_PMA_RST, S_FAIL};
      reset_pb_q <= state_d inside {S_IDLE, S_PMA_RST, S_PB_RST, S_FAIL};
      link_ok_q  <= (state_d == S_UP);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  always_ff @(posedge sysclk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_q     <= '0;
      serr_cnt_q <= '0;
    end else if (clear_counters_i) begin
      drop_q     <= '0;
      serr_cnt_q <= '0;
    end else begin
      if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + CNT_W'(1);
      end
      if (serr_rise && (serr_cnt_q != {CNT_W{1'b1}})) begin
        serr_cnt_q <= serr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pma_init_o       = pma_init_q;
  assign reset_pb_o       = reset_pb_q;
  assign link_ok_o        = link_ok_q;
  assign fail_o           = fail_q;
  assign state_o          = state_q;
  assign retry_count_o    = retry_q;
  assign drop_count_o     = drop_q;
  assign soft_err_count_o = serr_cnt_q;

endmodule
